// File: rtl/conv_stream_pkg.sv
// Shared types and constants for the 3x3 convolution tile streamer.
package conv_stream_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned FILTER_BEATS   = 9;
    localparam int unsigned TILE_BEATS     = 16;
    localparam int unsigned RESULT_BEATS   = 4;

    typedef enum logic [1:0] {
        StLoadF,
        StLoadI,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/conv_result_serializer.sv
// Captures the four 2x2 results and replays them as a valid/ready byte stream.
module conv_result_serializer
    import conv_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] result11,
    input  logic [DATA_W-1:0] result12,
    input  logic [DATA_W-1:0] result21,
    input  logic [DATA_W-1:0] result22,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              last
);

    localparam int unsigned IdxW = $clog2(RESULT_BEATS);

    logic [DATA_W-1:0] res_q [RESULT_BEATS];
    logic [IdxW-1:0]   out_idx_q;
    logic              valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RESULT_BEATS); i++) begin
                res_q[i] <= '0;
            end
            out_idx_q <= '0;
            valid_q   <= 1'b0;
        end else if (load) begin
            res_q[0]  <= result11;
            res_q[1]  <= result12;
            res_q[2]  <= result21;
            res_q[3]  <= result22;
            out_idx_q <= '0;
            valid_q   <= 1'b1;
        end else if (valid_q && m_ready) begin
            if (out_idx_q == IdxW'(RESULT_BEATS - 1)) begin
                out_idx_q <= '0;
                valid_q   <= 1'b0;
            end else begin
                out_idx_q <= out_idx_q + IdxW'(1);
            end
        end
    end

    assign m_valid = valid_q;
    // Gate the data so idle cycles read as zero rather than a stale result.
    assign m_data  = valid_q ? res_q[out_idx_q] : '0;
    assign last    = valid_q && m_ready && (out_idx_q == IdxW'(RESULT_BEATS - 1));

endmodule

// File: rtl/conv3x3_tile_streamer.sv
// Streams a 3x3 filter and 4x4 tile into the systolic array, sequences its reset,
// and streams the 2x2 result back out.
module conv3x3_tile_streamer
    import conv_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] mat_input11, mat_input12, mat_input13, mat_input14,
    output logic [DATA_W-1:0] mat_input21, mat_input22, mat_input23, mat_input24,
    output logic [DATA_W-1:0] mat_input31, mat_input32, mat_input33, mat_input34,
    output logic [DATA_W-1:0] mat_input41, mat_input42, mat_input43, mat_input44,
    output logic [DATA_W-1:0] filter11, filter12, filter13,
    output logic [DATA_W-1:0] filter21, filter22, filter23,
    output logic [DATA_W-1:0] filter31, filter32, filter33,
    output logic              arr_rst,
    input  logic              done_3_3,
    input  logic [DATA_W-1:0] result11,
    input  logic [DATA_W-1:0] result12,
    input  logic [DATA_W-1:0] result21,
    input  logic [DATA_W-1:0] result22,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [3:0]        beat_cnt_q;
    logic [CntW-1:0]   wait_cnt_q;
    logic              s_ready_q;
    logic              arr_rst_q;
    logic [DATA_W-1:0] filt_q [FILTER_BEATS];
    logic [DATA_W-1:0] tile_q [TILE_BEATS];

    logic s_hs;
    logic done_ok;
    logic timeout_hit;
    logic ser_last;

    assign s_hs        = s_valid && s_ready_q;
    // A done seen while wait_cnt is 0 may be left over from the previous run.
    assign done_ok     = (state_q == StRun) && done_3_3 && (wait_cnt_q != '0);
    assign timeout_hit = (state_q == StRun) && !done_ok && (wait_cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLoadF;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
            s_ready_q  <= 1'b0;
            arr_rst_q  <= 1'b1;
            for (int i = 0; i < int'(FILTER_BEATS); i++) filt_q[i] <= '0;
            for (int i = 0; i < int'(TILE_BEATS); i++)   tile_q[i] <= '0;
        end else begin
            unique case (state_q)
                StLoadF: begin
                    s_ready_q <= 1'b1;
                    if (s_hs) begin
                        filt_q[beat_cnt_q] <= s_data;
                        if (beat_cnt_q == 4'(FILTER_BEATS - 1)) begin
                            beat_cnt_q <= '0;
                            state_q    <= StLoadI;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 4'd1;
                        end
                    end
                end
                StLoadI: begin
                    if (s_hs) begin
                        tile_q[beat_cnt_q] <= s_data;
                        if (beat_cnt_q == 4'(TILE_BEATS - 1)) begin
                            beat_cnt_q <= '0;
                            wait_cnt_q <= '0;
                            s_ready_q  <= 1'b0;
                            arr_rst_q  <= 1'b0;
                            state_q    <= StRun;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 4'd1;
                        end
                    end
                end
                StRun: begin
                    wait_cnt_q <= wait_cnt_q + CntW'(1);
                    if (done_ok) begin
                        wait_cnt_q <= '0;
                        arr_rst_q  <= 1'b1;
                        state_q    <= StDrain;
                    end else if (timeout_hit) begin
                        wait_cnt_q <= '0;
                        arr_rst_q  <= 1'b1;
                        s_ready_q  <= 1'b1;
                        state_q    <= StLoadF;
                    end
                end
                StDrain: begin
                    if (ser_last) begin
                        s_ready_q <= 1'b1;
                        state_q   <= StLoadF;
                    end
                end
                default: state_q <= StLoadF;
            endcase
        end
    end

    conv_result_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (done_ok),
        .result11 (result11),
        .result12 (result12),
        .result21 (result21),
        .result22 (result22),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .last     (ser_last)
    );

    assign s_ready     = s_ready_q;
    assign arr_rst     = arr_rst_q;
    assign busy        = (state_q == StRun) || (state_q == StDrain);
    assign timeout_err = timeout_hit;

    assign filter11 = filt_q[0];
    assign filter12 = filt_q[1];
    assign filter13 = filt_q[2];
    assign filter21 = filt_q[3];
    assign filter22 = filt_q[4];
    assign filter23 = filt_q[5];
    assign filter31 = filt_q[6];
    assign filter32 = filt_q[7];
    assign filter33 = filt_q[8];

    assign mat_input11 = tile_q[0];
    assign mat_input12 = tile_q[1];
    assign mat_input13 = tile_q[2];
    assign mat_input14 = tile_q[3];
    assign mat_input21 = tile_q[4];
    assign mat_input22 = tile_q[5];
    assign mat_input23 = tile_q[6];
    assign mat_input24 = tile_q[7];
    assign mat_input31 = tile_q[8];
    assign mat_input32 = tile_q[9];
    assign mat_input33 = tile_q[10];
    assign mat_input34 = tile_q[11];
    assign mat_input41 = tile_q[12];
    assign mat_input42 = tile_q[13];
    assign mat_input43 = tile_q[14];
    assign mat_input44 = tile_q[15];

endmodule

// File: tb/tb_conv3x3_tile_streamer.sv
// Directed bench for conv3x3_tile_streamer with a behavioural 3x3 systolic array.
module tb_conv3x3_tile_streamer;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [7:0] mat_input11, mat_input12, mat_input13, mat_input14;
    logic [7:0] mat_input21, mat_input22, mat_input23, mat_input24;
    logic [7:0] mat_input31, mat_input32, mat_input33, mat_input34;
    logic [7:0] mat_input41, mat_input42, mat_input43, mat_input44;
    logic [7:0] filter11, filter12, filter13, filter21, filter22, filter23;
    logic [7:0] filter31, filter32, filter33;
    logic       arr_rst;
    logic       done_3_3;
    logic [7:0] result11, result12, result21, result22;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] stream [25] = '{1, 0, 1, 1, 1, 0, 0, 1, 1,
                                2, 1, 3, 1, 0, 2, 4, 2, 1, 3, 2, 0, 2, 1, 0, 1};
    logic [7:0] exp_res [4] = '{12, 10, 9, 10};

    conv3x3_tile_streamer #(
        .DATA_W  (8),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .mat_input11 (mat_input11), .mat_input12 (mat_input12),
        .mat_input13 (mat_input13), .mat_input14 (mat_input14),
        .mat_input21 (mat_input21), .mat_input22 (mat_input22),
        .mat_input23 (mat_input23), .mat_input24 (mat_input24),
        .mat_input31 (mat_input31), .mat_input32 (mat_input32),
        .mat_input33 (mat_input33), .mat_input34 (mat_input34),
        .mat_input41 (mat_input41), .mat_input42 (mat_input42),
        .mat_input43 (mat_input43), .mat_input44 (mat_input44),
        .filter11    (filter11), .filter12 (filter12), .filter13 (filter13),
        .filter21    (filter21), .filter22 (filter22), .filter23 (filter23),
        .filter31    (filter31), .filter32 (filter32), .filter33 (filter33),
        .arr_rst     (arr_rst),
        .done_3_3    (done_3_3),
        .result11    (result11),
        .result12    (result12),
        .result21    (result21),
        .result22    (result22),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buses gathered row-major for checking and for the array model.
    logic [7:0] filt_obs [9];
    logic [7:0] tile_obs [16];
    assign filt_obs[0] = filter11; assign filt_obs[1] = filter12; assign filt_obs[2] = filter13;
    assign filt_obs[3] = filter21; assign filt_obs[4] = filter22; assign filt_obs[5] = filter23;
    assign filt_obs[6] = filter31; assign filt_obs[7] = filter32; assign filt_obs[8] = filter33;
    assign tile_obs[0]  = mat_input11; assign tile_obs[1]  = mat_input12;
    assign tile_obs[2]  = mat_input13; assign tile_obs[3]  = mat_input14;
    assign tile_obs[4]  = mat_input21; assign tile_obs[5]  = mat_input22;
    assign tile_obs[6]  = mat_input23; assign tile_obs[7]  = mat_input24;
    assign tile_obs[8]  = mat_input31; assign tile_obs[9]  = mat_input32;
    assign tile_obs[10] = mat_input33; assign tile_obs[11] = mat_input34;
    assign tile_obs[12] = mat_input41; assign tile_obs[13] = mat_input42;
    assign tile_obs[14] = mat_input43; assign tile_obs[15] = mat_input44;

    // Array model: done after 3 cycles out of reset, results are the valid 3x3 convolution.
    logic       model_en;
    logic       force_done;
    logic [7:0] run_cnt;
    logic [7:0] model_res [4];

    always @(posedge clk) begin
        if (arr_rst) run_cnt <= 8'd0;
        else if (run_cnt != 8'hff) run_cnt <= run_cnt + 8'd1;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            model_res[k] = 8'd0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    model_res[k] = model_res[k] +
                        8'(filt_obs[i*3+j] * tile_obs[((k/2)+i)*4 + (k%2) + j]);
                end
            end
        end
    end

    assign done_3_3 = force_done || (model_en && !arr_rst && run_cnt >= 8'd3);
    assign result11 = model_res[0];
    assign result12 = model_res[1];
    assign result21 = model_res[2];
    assign result22 = model_res[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Sends the first n stream bytes; returns at the negedge after the last handshake.
    task automatic send_stream(input int n, input bit gaps);
        int  i = 0;
        int  guard = 0;
        bit  toggle = 1'b0;
        while (i < n && guard < 200) begin
            @(negedge clk);
            if (gaps && toggle) begin
                s_valid = 1'b0;
                toggle  = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = stream[i];
                toggle  = 1'b1;
                if (s_ready) i++;
            end
            guard++;
        end
        chk("send_beats", i, n);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic chk_operands();
        for (int i = 0; i < 9; i++)  chk("filter_bus", filt_obs[i], stream[i]);
        for (int i = 0; i < 16; i++) chk("tile_bus", tile_obs[i], stream[9+i]);
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!m_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Called at the negedge of the first RUN cycle; drains all four results.
    task automatic collect(input int stall);
        int waited;
        m_ready = (stall == 0);
        wait_valid(waited);
        chk("m_valid_latency", waited, 4);
        chk("arr_rst_in_drain", arr_rst, 1'b1);
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < stall; s++) begin
                m_ready = 1'b0;
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, exp_res[k]);
                @(negedge clk);
            end
            m_ready = 1'b1;
            chk("beat_valid", m_valid, 1'b1);
            chk("beat_data", m_data, exp_res[k]);
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("drain_done_valid", m_valid, 1'b0);
        chk("ready_after_drain", s_ready, 1'b1);
        chk("busy_after_drain", busy, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_arr_rst", arr_rst, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_filter11", filter11, 8'd0);
        chk("rst_mat11", mat_input11, 8'd0);
    endtask

    initial begin
        int waited;
        int pulses;
        int pulse_rc;
        bit seen_valid;
        bit ready8;
        bit ready9;

        rst = 1'b1; s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b0;
        model_en = 1'b1; force_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", s_ready, 1'b1);

        // Nominal stream.
        send_stream(25, 1'b0);
        chk("nom_arr_rst_low", arr_rst, 1'b0);
        chk("nom_s_ready_low", s_ready, 1'b0);
        chk("nom_busy", busy, 1'b1);
        chk_operands();
        collect(0);

        // Gapped input stream.
        send_stream(25, 1'b1);
        chk_operands();
        collect(0);

        // Output backpressure.
        send_stream(25, 1'b0);
        collect(3);

        // Stale done in the first RUN cycle, then no done at all until timeout.
        model_en = 1'b0;
        send_stream(25, 1'b0);
        force_done = 1'b1;
        pulses = 0; pulse_rc = 0; seen_valid = 1'b0; ready8 = 1'b0; ready9 = 1'b0;
        for (int rc = 1; rc <= 12; rc++) begin
            if (rc == 2) begin
                force_done = 1'b0;
                chk("stale_busy", busy, 1'b1);
                chk("stale_arr_rst", arr_rst, 1'b0);
            end
            if (timeout_err) begin
                pulses++;
                pulse_rc = rc;
            end
            if (m_valid) seen_valid = 1'b1;
            if (rc == 8) ready8 = s_ready;
            if (rc == 9) ready9 = s_ready;
            @(negedge clk);
        end
        chk("timeout_pulses", pulses, 1);
        chk("timeout_cycle", pulse_rc, 8);
        chk("timeout_no_valid", seen_valid, 1'b0);
        chk("timeout_ready_during", ready8, 1'b0);
        chk("timeout_ready_after", ready9, 1'b1);
        model_en = 1'b1;

        // Reset after 12 input beats, then a fresh run.
        send_stream(12, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midload_rst", s_ready, 1'b1);
        send_stream(25, 1'b0);
        chk_operands();
        collect(0);

        // Reset after the first output beat, then a fresh run.
        send_stream(25, 1'b0);
        m_ready = 1'b1;
        wait_valid(waited);
        chk("md_first_data", m_data, exp_res[0]);
        @(negedge clk);
        m_ready = 1'b0;
        chk("md_second_data", m_data, exp_res[1]);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_middrain_rst", s_ready, 1'b1);
        send_stream(25, 1'b0);
        collect(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv3x3_tile_streamer.md
# conv3x3_tile_streamer

Stream-side wrapper directly upstream and downstream of `systolic_array_3by3_module`. It accepts a byte stream of one 3x3 filter followed by one 4x4 input tile and presents them as the array's 25 parallel operand buses. It sequences the array's `rst` and waits for `done_3_3`. It then captures the 2x2 result and replays it as a 4-beat byte stream, so the array can sit behind a single valid/ready link.

## Interface
- `DATA_W`, 8, width of every operand, result and stream byte
- `TIMEOUT`, 64, max cycles in RUN waiting for `done_3_3` before abort
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  reset, synchronous and active-high
- `s_valid`  in  1  input beat valid
- `s_data`  in  DATA_W  input beat: 9 filter bytes, then 16 tile bytes, each row-major
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`
- `mat_input11`..`mat_input44`  out  DATA_W each  tile operands to array
- `filter11`..`filter33`  out  DATA_W each  filter operands to array
- `arr_rst`  out  1  drives array `rst`; high = array held/idle
- `done_3_3`  in  1  array completion
- `result11`, `result12`, `result21`, `result22`  in  DATA_W each  array results
- `m_valid`  out  1  output beat valid
- `m_data`  out  DATA_W  output beat: result11, result12, result21, result22
- `m_ready`  in  1  output beat accepted when `m_valid && m_ready`
- `busy`  out  1  high in RUN and DRAIN
- `timeout_err`  out  1  one-cycle pulse on RUN abort

## Operation
- FSM: LOAD_F -> LOAD_I -> RUN -> DRAIN -> LOAD_F. RUN also exits to LOAD_F on timeout.
- LOAD_F: `s_ready`=1. Each accepted beat is written to filter register `beat_cnt` (0..8, row-major). Accepting beat 8 moves the FSM to LOAD_I with `beat_cnt` cleared.
- LOAD_I: same behaviour, writing 16 tile registers (0..15). Accepting beat 15 moves the FSM to RUN.
- RUN: `s_ready`=0 and `arr_rst`=0. Operand registers stay frozen. `wait_cnt` increments each cycle.
  - `done_3_3` is honoured only once `arr_rst` has been low for at least one full cycle, i.e. `wait_cnt` ≥ 1. This blocks a stale done.
  - When `done_3_3` is honoured, the 4 results are captured into the result buffer and the FSM moves to DRAIN.
  - If `wait_cnt` reaches `TIMEOUT` with no done, `timeout_err` pulses, nothing is emitted, and the FSM moves to LOAD_F.
- DRAIN: `arr_rst`=1, `m_valid`=1, `m_data`=buf[`out_idx`]. `out_idx` advances on each handshake. The handshake on index 3 moves the FSM to LOAD_F.
- `m_data` stays stable while `m_valid && !m_ready` (stall).
- Operand registers keep their last values outside the LOAD states. They are overwritten only by accepted beats.
- Results are passed through unmodified, with no width change. Wrap or saturation is the array's responsibility.

## Timing
- Reset values: state LOAD_F, all operand regs 0, result buffer 0, `arr_rst`=1, `s_ready`=0 while `rst`=1, `m_valid`=0, `m_data`=0, `busy`=0, `timeout_err`=0. All counters 0.
- `s_ready` becomes 1 in the first cycle after `rst` falls.
- `s_ready` and `m_valid` are decoded from registered state, with no combinational path from `s_valid` or `m_ready`.
- `arr_rst` falls in the cycle after the 25th input handshake.
- Earliest honoured done is the second cycle with `arr_rst`=0.
- `m_valid` rises the cycle after done is honoured. At the same edge, `arr_rst` returns to 1.
- DRAIN with `m_ready` held at 1 takes exactly 4 cycles. `s_ready` becomes 1 the cycle after the last output handshake.
- A new input stream cannot overlap DRAIN, because `s_ready`=0 throughout.
- `rst` asserted in any state returns the block to reset values on the next edge. Partial loads and pending results are discarded.

## Structure
- Package `conv_stream_pkg`:
  - state enum
  - `FILTER_BEATS`=9, `TILE_BEATS`=16, `RESULT_BEATS`=4
  - default `DATA_W`
- One sub-module, `conv_result_serializer`: 4-entry capture buffer plus `out_idx` and the valid/ready output side. It has a load strobe and a `last` indication back to the FSM.

## Test plan
- Nominal: stream filter 1,0,1,1,1,0,0,1,1, then tile 2,1,3,1,0,2,4,2,1,3,2,0,2,1,0,1, with the array model and `m_ready`=1 -> operand buses match row-major order, `arr_rst` falls one cycle after the last beat, `m_data` = 12,10,9,10 on consecutive cycles, then `s_ready`=1.
- Input gaps: `s_valid` toggled 1/0 every cycle over the same data -> identical operands and identical output 12,10,9,10.
- Output backpressure: `m_ready` low for 3 cycles on each beat -> each `m_data` value held stable until accepted, with no beat lost or duplicated.
- Stale done: `done_3_3` forced high in the first RUN cycle only -> ignored, no capture, FSM stays in RUN.
- Timeout (`TIMEOUT`=8): array never asserts done -> `timeout_err` pulses once on the 8th RUN cycle, `m_valid` never asserts, `s_ready`=1 the next cycle.
- Reset mid-load after beat 12, and mid-DRAIN after beat 1 -> all outputs at reset values the next cycle, then a full fresh tile produces correct results.
